// File: rtl/frame_stats.sv
// frame_stats: per-frame peak |sample|, peak index and energy over a
// valid/ready sample stream, presented on a held valid/ready result port.
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   sample_data_i/valid_i/ready_o    signed sample stream
//   frame_start_i                    realigns the frame to index 0
//   peak_abs_o, peak_index_o         peak magnitude and first index of it
//   energy_o                         sum of squares over the frame
//   stats_valid_o/stats_ready_i      result handshake
//   frame_count_o                    completed frames (wraps)
//   frame_short_o                    pulse when a partial frame is dropped
module frame_stats #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [WIDTH-1:0]                sample_data_i,
   input  logic                            sample_valid_i,
   output logic                            sample_ready_o,
   input  logic                            frame_start_i,
   output logic [WIDTH-1:0]                peak_abs_o,
   output logic [ADDR_WIDTH-1:0]           peak_index_o,
   output logic [2*WIDTH+ADDR_WIDTH-1:0]   energy_o,
   output logic                            stats_valid_o,
   input  logic                            stats_ready_i,
   output logic [15:0]                     frame_count_o,
   output logic                            frame_short_o
);

   localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
   localparam int unsigned PROD_W   = 2 * WIDTH;
   localparam int unsigned ENERGY_W = 2 * WIDTH + ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  accept_c, clear_c, hold_entry_c, short_d;
   logic [CNT_W-1:0]      sample_cnt;
   logic [WIDTH-1:0]      abs_c, abs_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic                  s1_valid;
   logic [WIDTH-1:0]      peak_acc, peak_nxt;
   logic [ADDR_WIDTH-1:0] idx_acc, idx_nxt;
   logic [ENERGY_W-1:0]   energy_acc, energy_nxt;
   logic [PROD_W-1:0]     sq_c;

   assign accept_c = sample_valid_i && sample_ready_o;

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
   assign abs_c = sample_data_i[WIDTH-1] ? (~sample_data_i + WIDTH'(1)) : sample_data_i;

   // Stage 2 next values, also used to latch the result at HOLD entry so the
   // final sample absorbed during DRAIN is included.
   always_comb begin
      sq_c       = PROD_W'(abs_q) * PROD_W'(abs_q);
      peak_nxt   = peak_acc;
      idx_nxt    = idx_acc;
      energy_nxt = energy_acc;
      if (s1_valid) begin
         energy_nxt = energy_acc + ENERGY_W'(sq_c);
         if (abs_q > peak_acc) begin
            peak_nxt = abs_q;
            idx_nxt  = idx_q;
         end
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_COLLECT;
      else         state_q <= state_d;
   end

   // Next-state and control decode.
   always_comb begin
      state_d      = state_q;
      clear_c      = 1'b0;
      hold_entry_c = 1'b0;
      short_d      = 1'b0;
      unique case (state_q)
         ST_COLLECT: begin
            if (frame_start_i) begin
               clear_c = 1'b1;
               short_d = (sample_cnt != '0);
            end else if (accept_c && sample_cnt == CNT_W'(DEPTH - 1)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d      = ST_HOLD;
            hold_entry_c = 1'b1;
         end
         ST_HOLD: begin
            if (stats_valid_o && stats_ready_i) begin
               state_d = ST_COLLECT;
               clear_c = 1'b1;
            end
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   // Sample counter, stage 1 and stage 2 accumulators.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sample_cnt <= '0;
         abs_q      <= '0;
         idx_q      <= '0;
         s1_valid   <= 1'b0;
         peak_acc   <= '0;
         idx_acc    <= '0;
         energy_acc <= '0;
      end else begin
         if (clear_c)       sample_cnt <= accept_c ? CNT_W'(1) : '0;
         else if (accept_c) sample_cnt <= sample_cnt + CNT_W'(1);

         s1_valid <= accept_c;
         if (accept_c) begin
            abs_q <= abs_c;
            idx_q <= clear_c ? '0 : sample_cnt[ADDR_WIDTH-1:0];
         end

         if (clear_c) begin
            peak_acc   <= '0;
            idx_acc    <= '0;
            energy_acc <= '0;
         end else begin
            peak_acc   <= peak_nxt;
            idx_acc    <= idx_nxt;
            energy_acc <= energy_nxt;
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sample_ready_o <= 1'b1;
         peak_abs_o     <= '0;
         peak_index_o   <= '0;
         energy_o       <= '0;
         stats_valid_o  <= 1'b0;
         frame_count_o  <= '0;
         frame_short_o  <= 1'b0;
      end else begin
         sample_ready_o <= (state_d == ST_COLLECT);
         frame_short_o  <= short_d;
         if (hold_entry_c) begin
            peak_abs_o    <= peak_nxt;
            peak_index_o  <= idx_nxt;
            energy_o      <= energy_nxt;
            stats_valid_o <= 1'b1;
            frame_count_o <= frame_count_o + 16'(1);
         end else if (stats_valid_o && stats_ready_i) begin
            stats_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_frame_stats.sv
module tb_frame_stats;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 3;
   localparam int unsigned EW    = 2 * WIDTH + AW;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic [WIDTH-1:0]  sample_data_i = '0;
   logic              sample_valid_i = 1'b0;
   logic              sample_ready_o;
   logic              frame_start_i = 1'b0;
   logic [WIDTH-1:0]  peak_abs_o;
   logic [AW-1:0]     peak_index_o;
   logic [EW-1:0]     energy_o;
   logic              stats_valid_o;
   logic              stats_ready_i = 1'b0;
   logic [15:0]       frame_count_o;
   logic              frame_short_o;

   int errors = 0;
   int checks = 0;
   int short_pulses = 0;
   int short_run = 0;
   int short_wide = 0;

   frame_stats #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .sample_data_i(sample_data_i), .sample_valid_i(sample_valid_i),
      .sample_ready_o(sample_ready_o), .frame_start_i(frame_start_i),
      .peak_abs_o(peak_abs_o), .peak_index_o(peak_index_o), .energy_o(energy_o),
      .stats_valid_o(stats_valid_o), .stats_ready_i(stats_ready_i),
      .frame_count_o(frame_count_o), .frame_short_o(frame_short_o)
   );

   always #5 clk_i = ~clk_i;

   // Count frame_short pulses and flag any pulse wider than one cycle.
   always @(negedge clk_i) begin
      if (frame_short_o) begin
         if (short_run == 0) short_pulses++;
         short_run++;
         if (short_run > 1) short_wide++;
      end else begin
         short_run = 0;
      end
   end

   task automatic tick();
      @(posedge clk_i); #1;
   endtask

   // Present one sample and return 1 ns after the edge that accepted it.
   task automatic send(input logic [WIDTH-1:0] v);
      int n = 0;
      sample_data_i  = v;
      sample_valid_i = 1'b1;
      while (!sample_ready_o && n < 50) begin tick(); n++; end
      checks++;
      if (!sample_ready_o) begin
         errors++;
         $display("FAIL send_timeout: sample_ready_o=%0b required 1", sample_ready_o);
      end
      tick();
      sample_valid_i = 1'b0;
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] f [DEPTH]);
      for (int i = 0; i < int'(DEPTH); i++) send(f[i]);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) tick();
      checks++;
      if (sample_ready_o !== 1'b1 || stats_valid_o !== 1'b0 || peak_abs_o !== '0 ||
          peak_index_o !== '0 || energy_o !== '0 || frame_count_o !== '0 || frame_short_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_in: rdy=%0b vld=%0b peak=%0d idx=%0d en=%0d cnt=%0d short=%0b required rdy=1 rest 0",
                  sample_ready_o, stats_valid_o, peak_abs_o, peak_index_o, energy_o, frame_count_o, frame_short_o);
      end
      #3 rst_ni = 1'b1;
      tick();
      checks++;
      if (sample_ready_o !== 1'b1 || stats_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: rdy=%0b vld=%0b required rdy=1 vld=0", sample_ready_o, stats_valid_o);
      end
   endtask

   task automatic test_ramp();
      logic [WIDTH-1:0] f [DEPTH];
      f = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      stats_ready_i = 1'b1;
      send_frame(f);
      checks++;
      if (sample_ready_o !== 1'b0 || stats_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL ramp_drain: rdy=%0b vld=%0b required 0 0", sample_ready_o, stats_valid_o);
      end
      tick();
      checks++;
      if (stats_valid_o !== 1'b1 || peak_abs_o !== 16'd8 || peak_index_o !== 3'd7 ||
          energy_o !== EW'(204) || frame_count_o !== 16'd1) begin
         errors++;
         $display("FAIL ramp_result: vld=%0b peak=%0d idx=%0d en=%0d cnt=%0d required 1 8 7 204 1",
                  stats_valid_o, peak_abs_o, peak_index_o, energy_o, frame_count_o);
      end
      tick();
      checks++;
      if (sample_ready_o !== 1'b1 || stats_valid_o !== 1'b0 || peak_abs_o !== 16'd8 || energy_o !== EW'(204)) begin
         errors++;
         $display("FAIL ramp_after_hs: rdy=%0b vld=%0b peak=%0d en=%0d required 1 0 8 204",
                  sample_ready_o, stats_valid_o, peak_abs_o, energy_o);
      end
   endtask

   task automatic test_negative_ties();
      logic [WIDTH-1:0] f [DEPTH];
      f = '{16'h8000, 16'd5, 16'hFFFB, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd0};
      stats_ready_i = 1'b1;
      send_frame(f);
      tick();
      // 32768^2 + 25 + 25 + 32767^2
      checks++;
      if (stats_valid_o !== 1'b1 || peak_abs_o !== 16'd32768 || peak_index_o !== 3'd0 ||
          energy_o !== EW'(64'd2147418163) || frame_count_o !== 16'd2) begin
         errors++;
         $display("FAIL neg_result: vld=%0b peak=%0d idx=%0d en=%0d cnt=%0d required 1 32768 0 2147418163 2",
                  stats_valid_o, peak_abs_o, peak_index_o, energy_o, frame_count_o);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] f [DEPTH];
      int bad = 0;
      f = '{16'd3, 16'hFFF9, 16'd7, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
      stats_ready_i = 1'b0;
      send_frame(f);
      tick();
      sample_data_i  = 16'd99;
      sample_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (sample_ready_o !== 1'b0 || stats_valid_o !== 1'b1 || peak_abs_o !== 16'd7 ||
             peak_index_o !== 3'd1 || energy_o !== EW'(108) || frame_count_o !== 16'd3) begin
            errors++;
            bad++;
            if (bad < 4)
               $display("FAIL bp_hold[%0d]: rdy=%0b vld=%0b peak=%0d idx=%0d en=%0d cnt=%0d required 0 1 7 1 108 3",
                        i, sample_ready_o, stats_valid_o, peak_abs_o, peak_index_o, energy_o, frame_count_o);
         end
         tick();
      end
      stats_ready_i  = 1'b1;
      sample_valid_i = 1'b0;
      tick();
      checks++;
      if (sample_ready_o !== 1'b1 || stats_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: rdy=%0b vld=%0b required 1 0", sample_ready_o, stats_valid_o);
      end
      f = '{16'd4, 16'd4, 16'hFFFC, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4};
      send_frame(f);
      tick();
      checks++;
      if (stats_valid_o !== 1'b1 || peak_abs_o !== 16'd4 || peak_index_o !== 3'd0 ||
          energy_o !== EW'(128) || frame_count_o !== 16'd4) begin
         errors++;
         $display("FAIL bp_next: vld=%0b peak=%0d idx=%0d en=%0d cnt=%0d required 1 4 0 128 4",
                  stats_valid_o, peak_abs_o, peak_index_o, energy_o, frame_count_o);
      end
      tick();
   endtask

   task automatic test_resync();
      int p0 = short_pulses;
      stats_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) send(16'd5);
      frame_start_i = 1'b1;
      send(16'd9);
      frame_start_i = 1'b0;
      checks++;
      if (frame_short_o !== 1'b1) begin
         errors++;
         $display("FAIL resync_pulse: frame_short_o=%0b required 1", frame_short_o);
      end
      for (int i = 0; i < 7; i++) send(16'd1);
      tick();
      checks++;
      if (stats_valid_o !== 1'b1 || peak_abs_o !== 16'd9 || peak_index_o !== 3'd0 ||
          energy_o !== EW'(88) || frame_count_o !== 16'd5) begin
         errors++;
         $display("FAIL resync_result: vld=%0b peak=%0d idx=%0d en=%0d cnt=%0d required 1 9 0 88 5",
                  stats_valid_o, peak_abs_o, peak_index_o, energy_o, frame_count_o);
      end
      checks++;
      if (short_pulses - p0 !== 1 || short_wide !== 0) begin
         errors++;
         $display("FAIL resync_count: pulses=%0d wide=%0d required 1 0", short_pulses - p0, short_wide);
      end
      tick();
   endtask

   task automatic test_ignored_start();
      logic [WIDTH-1:0] f [DEPTH];
      int p0 = short_pulses;
      f = '{16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd3};
      stats_ready_i = 1'b0;
      send_frame(f);
      frame_start_i = 1'b1;   // DRAIN cycle
      tick();
      frame_start_i = 1'b1;   // first HOLD cycle
      tick();
      frame_start_i = 1'b0;
      tick();
      checks++;
      if (stats_valid_o !== 1'b1 || peak_abs_o !== 16'd3 || peak_index_o !== 3'd7 ||
          energy_o !== EW'(37) || frame_count_o !== 16'd6 || sample_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL ignored_result: vld=%0b peak=%0d idx=%0d en=%0d cnt=%0d rdy=%0b required 1 3 7 37 6 0",
                  stats_valid_o, peak_abs_o, peak_index_o, energy_o, frame_count_o, sample_ready_o);
      end
      checks++;
      if (short_pulses !== p0) begin
         errors++;
         $display("FAIL ignored_pulse: pulses=%0d required 0", short_pulses - p0);
      end
      stats_ready_i = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_frame();
      logic [WIDTH-1:0] f [DEPTH];
      int p0 = short_pulses;
      stats_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) send(16'd7);
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (sample_ready_o !== 1'b1 || stats_valid_o !== 1'b0 || peak_abs_o !== '0 || peak_index_o !== '0 ||
          energy_o !== '0 || frame_count_o !== '0 || frame_short_o !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: rdy=%0b vld=%0b peak=%0d idx=%0d en=%0d cnt=%0d short=%0b required rdy=1 rest 0",
                  sample_ready_o, stats_valid_o, peak_abs_o, peak_index_o, energy_o, frame_count_o, frame_short_o);
      end
      tick();
      #3 rst_ni = 1'b1;
      tick();
      f = '{16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
      send_frame(f);
      tick();
      checks++;
      if (stats_valid_o !== 1'b1 || peak_abs_o !== 16'd2 || peak_index_o !== 3'd0 ||
          energy_o !== EW'(32) || frame_count_o !== 16'd1) begin
         errors++;
         $display("FAIL midreset_frame: vld=%0b peak=%0d idx=%0d en=%0d cnt=%0d required 1 2 0 32 1",
                  stats_valid_o, peak_abs_o, peak_index_o, energy_o, frame_count_o);
      end
      checks++;
      if (short_pulses !== p0) begin
         errors++;
         $display("FAIL midreset_pulse: pulses=%0d required 0", short_pulses - p0);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_negative_ties();
      test_backpressure();
      test_resync();
      test_ignored_start();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
